// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stop/no-stop levels,
// stall vector encodings and arbiter state encodings.
package pipe_ctrl_pkg;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   // Stall vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   // Shared memory port arbiter states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_ACC  = 2'd1,
      MEM_ACC = 2'd2
   } arb_state_e;

endpackage

// File: rtl/pipe_ctrl_wdt.sv
// Access watchdog: counts consecutive cycles of one memory access and raises
// a sticky error when the count reaches WDT_LIMIT. Only built when
// PIPE_CTRL_WDT_EN is defined.
module pipe_ctrl_wdt #(
   parameter int WDT_LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   output logic wdt_err
);

   logic [7:0] cnt_q;

   // Count busy cycles (saturating), clear when idle; latch error until reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= 8'd0;
         wdt_err <= 1'b0;
      end else begin
         if (!busy)
            cnt_q <= 8'd0;
         else if (cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
         // The cycle being counted now is cycle cnt_q+1 of this access.
         if (busy && (({1'b0, cnt_q} + 9'd1) >= 9'(WDT_LIMIT)))
            wdt_err <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates one shared memory port between IF and MEM,
// generates the stall vector and branch flush, and drops fetches that
// belong to a flushed path. Optional access watchdog under PIPE_CTRL_WDT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int WDT_LIMIT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       if_req,
   input  logic       mem_req,
   input  logic       mem_done,
   input  logic       id_stallreq,
   input  logic       ex_stallreq,
   input  logic       branch_flag,
   output logic [5:0] stall,
   output logic       flush,
   output logic       grant_if,
   output logic       grant_mem,
   output logic       if_discard,
   output logic       wdt_err
);

   arb_state_e state_q, state_d;
   logic       drop_q, drop_d;
   logic       if_done, mem_acc_done;

   assign if_done      = (state_q == IF_ACC)  && mem_done;
   assign mem_acc_done = (state_q == MEM_ACC) && mem_done;

   // Grants decode directly from the state register, so they are registered
   assign grant_if  = (state_q == IF_ACC);
   assign grant_mem = (state_q == MEM_ACC);

   // State and drop-flag registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!rst) begin
         state_q <= IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // Next state, stall priority chain, flush and fetch-discard decode
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d    = state_q;
      drop_d     = 1'b0;
      stall      = STALL_NONE;
      flush      = 1'b0;
      if_discard = 1'b0;

      if (mem_req && !mem_acc_done)
         stall = STALL_MEM;
      else if (ex_stallreq)
         stall = STALL_EX;
      else if (id_stallreq)
         stall = STALL_ID;
      else if (if_req && !if_done)
         stall = STALL_IF;

      flush = branch_flag && (stall[3] == NOSTOP);

      unique case (state_q)
         IDLE: begin
            if (mem_req)
               state_d = MEM_ACC;
            else if (if_req)
               state_d = IF_ACC;
         end
         IF_ACC: begin
            if (mem_done) begin
               state_d    = IDLE;
               if_discard = drop_q || flush;
            end else begin
               drop_d = drop_q || flush;
            end
         end
         MEM_ACC: begin
            if (mem_done)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset overrides all combinational outputs regardless of inputs.
      if (!rst) begin
         stall      = STALL_NONE;
         flush      = 1'b0;
         if_discard = 1'b0;
      end
   end

`ifdef PIPE_CTRL_WDT_EN
   pipe_ctrl_wdt #(
      .WDT_LIMIT (WDT_LIMIT)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .busy    (state_q != IDLE),
      .wdt_err (wdt_err)
   );
`else
   assign wdt_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (WDT_LIMIT=4). Expected watchdog
// behaviour follows PIPE_CTRL_WDT_EN.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       if_req, mem_req, mem_done, id_stallreq, ex_stallreq, branch_flag;
   logic [5:0] stall;
   logic       flush, grant_if, grant_mem, if_discard, wdt_err;

   int checks = 0;
   int errors = 0;

`ifdef PIPE_CTRL_WDT_EN
   localparam logic WDT_ON = 1'b1;
`else
   localparam logic WDT_ON = 1'b0;
`endif

   pipe_ctrl #(.WDT_LIMIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .mem_req     (mem_req),
      .mem_done    (mem_done),
      .id_stallreq (id_stallreq),
      .ex_stallreq (ex_stallreq),
      .branch_flag (branch_flag),
      .stall       (stall),
      .flush       (flush),
      .grant_if    (grant_if),
      .grant_mem   (grant_mem),
      .if_discard  (if_discard),
      .wdt_err     (wdt_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Check the full observable output set at once
   task automatic chk_all(input string tag, input logic [5:0] e_stall, input logic e_flush,
                          input logic e_gif, input logic e_gmem, input logic e_disc);
      chk({tag, ".stall"},      {2'b00, stall}, {2'b00, e_stall});
      chk({tag, ".flush"},      {7'd0, flush},      {7'd0, e_flush});
      chk({tag, ".grant_if"},   {7'd0, grant_if},   {7'd0, e_gif});
      chk({tag, ".grant_mem"},  {7'd0, grant_mem},  {7'd0, e_gmem});
      chk({tag, ".if_discard"}, {7'd0, if_discard}, {7'd0, e_disc});
   endtask

   // Advance one clock and settle past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b0; if_req = 1'b0; mem_req = 1'b1; mem_done = 1'b0;
      id_stallreq = 1'b1; ex_stallreq = 1'b1; branch_flag = 1'b1;
      step(); step();
      // Reset forces outputs quiet regardless of inputs
      settle();
      chk_all("reset", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.wdt_err", {7'd0, wdt_err}, 8'd0);

      // Both requests in IDLE: MEM wins
      mem_req = 1'b1; if_req = 1'b1; id_stallreq = 1'b0; ex_stallreq = 1'b0;
      branch_flag = 1'b0; settle();
      rst = 1'b1; settle();
      chk_all("both_idle", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("mem_grant", 6'b011111, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk_all("mem_wait", 6'b011111, 1'b0, 1'b0, 1'b1, 1'b0);
      mem_done = 1'b1; settle();
      chk_all("mem_done", 6'b000011, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      mem_done = 1'b0; mem_req = 1'b0; settle();
      chk_all("turnaround", 6'b000011, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      // IF access, mem_done three cycles after grant
      chk_all("if_grant", 6'b000011, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("if_wait1", 6'b000011, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("if_wait2", 6'b000011, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      mem_done = 1'b1; settle();
      chk_all("if_done", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      mem_done = 1'b0; if_req = 1'b0; settle();
      chk_all("if_back_idle", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // mem_done in IDLE is ignored
      mem_done = 1'b1; step();
      mem_done = 1'b0; settle();
      chk_all("stray_done", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // EX stall blocks flush; releasing it lets the branch flush
      ex_stallreq = 1'b1; branch_flag = 1'b1; settle();
      chk_all("ex_branch", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0);
      ex_stallreq = 1'b0; settle();
      chk_all("branch_free", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
      branch_flag = 1'b0;
      id_stallreq = 1'b1; settle();
      chk_all("id_stall", 6'b000111, 1'b0, 1'b0, 1'b0, 1'b0);
      id_stallreq = 1'b0;

      // Flush during IF access sets drop flag; discard on the ending mem_done
      if_req = 1'b1; step();
      if_req = 1'b0; branch_flag = 1'b1; settle();
      chk_all("if_flush", 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      branch_flag = 1'b0; settle();
      chk_all("if_drop_wait", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      mem_done = 1'b1; settle();
      chk_all("if_discard", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      mem_done = 1'b0; settle();
      chk_all("drop_cleared", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flush coincident with mem_done discards directly
      if_req = 1'b1; step();
      if_req = 1'b0; step();
      mem_done = 1'b1; branch_flag = 1'b1; settle();
      chk_all("if_coincident", 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      mem_done = 1'b0; branch_flag = 1'b0;

      // Flush in MEM_ACC does not set the drop flag
      if_req = 1'b1; step();
      if_req = 1'b0; mem_req = 1'b0; mem_done = 1'b1; step();
      mem_done = 1'b0; mem_req = 1'b1; step();
      mem_req = 1'b0; settle();
      chk_all("mem_acc2", 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
      branch_flag = 1'b1; step();
      branch_flag = 1'b0; mem_done = 1'b1; step();
      mem_done = 1'b0; if_req = 1'b1; step();
      if_req = 1'b0; settle();
      chk_all("if_after_mem", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);
      mem_done = 1'b1; settle();
      chk_all("no_drop_from_mem", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      mem_done = 1'b0;

      // Reset mid MEM access abandons it; later mem_done ignored
      mem_req = 1'b1; step();
      settle();
      chk_all("mem_pre_rst", 6'b011111, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0; settle();
      chk_all("mid_rst", 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      rst = 1'b1; mem_req = 1'b0; mem_done = 1'b1; settle();
      chk_all("post_rst", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      mem_done = 1'b0; settle();
      chk_all("post_rst_done", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("wdt_clear", {7'd0, wdt_err}, 8'd0);

      // Watchdog: MEM access with no mem_done, limit 4
      mem_req = 1'b1; step();
      mem_req = 1'b0; step(); step(); step();
      chk("wdt_3cyc", {7'd0, wdt_err}, 8'd0);
      step();
      chk("wdt_4cyc", {7'd0, wdt_err}, {7'd0, WDT_ON});
      mem_done = 1'b1; step();
      mem_done = 1'b0; step();
      chk("wdt_sticky", {7'd0, wdt_err}, {7'd0, WDT_ON});
      chk("wdt_idle_grant", {7'd0, grant_mem}, 8'd0);
      rst = 1'b0; step();
      rst = 1'b1; settle();
      chk("wdt_reset", {7'd0, wdt_err}, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WDT_LIMIT, default 255, the consecutive-cycle bound for one memory access (only used with PIPE_CTRL_WDT_EN).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port if_req  in  1  IF stage requests an instruction fetch on the shared memory port.
REQ-005 SHALL have port mem_req  in  1  MEM stage requests a load/store on the shared memory port.
REQ-006 SHALL have port mem_done  in  1  one-cycle pulse: the memory port completed the granted access.
REQ-007 SHALL have port id_stallreq  in  1  load-use hazard detected in ID.
REQ-008 SHALL have port ex_stallreq  in  1  multi-cycle operation in EX.
REQ-009 SHALL have port branch_flag  in  1  EX resolved a taken branch or jump.
REQ-010 SHALL have port stall  out  6  stall vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-011 SHALL have port flush  out  1  clears IF/ID and ID/EX on the next edge.
REQ-012 SHALL have port grant_if, grant_mem  out  1 each  registered memory-port grants, mutually exclusive.
REQ-013 SHALL have port if_discard  out  1  one-cycle pulse: completed fetch belongs to a flushed path and must be dropped.
REQ-014 SHALL have port wdt_err  out  1  sticky watchdog error.

Function
REQ-015 SHALL implement arbiter FSM states IDLE, IF_ACC, MEM_ACC; grant_if=1 only in IF_ACC, grant_mem=1 only in MEM_ACC.
REQ-016 IDLE SHALL go to MEM_ACC if mem_req, else to IF_ACC if if_req, else stay; mem_req wins when both assert.
REQ-017 IF_ACC and MEM_ACC SHALL return to IDLE on mem_done; mem_done in IDLE SHALL be ignored.
REQ-018 Grant latency SHALL be one cycle after the request is sampled in IDLE; minimum access = 2 cycles (grant, done), plus one IDLE turnaround cycle before the next grant.
REQ-019 stall SHALL be combinational, highest priority first: MEM waiting (mem_req and not (MEM_ACC and mem_done)) -> 011111; ex_stallreq -> 001111; id_stallreq -> 000111; IF waiting (if_req and not (IF_ACC and mem_done)) -> 000011; else 000000.
REQ-020 flush SHALL equal branch_flag and stall[3]==NoStop, same cycle.
REQ-021 A flush while in IF_ACC without mem_done SHALL set a drop flag; the mem_done ending that access SHALL assert if_discard for that cycle and clear the flag.
REQ-022 A flush in IF_ACC coincident with mem_done SHALL assert if_discard that cycle directly.
REQ-023 A flush in IDLE or MEM_ACC SHALL NOT set the drop flag.

Reset
REQ-024 With rst low at an edge: state IDLE, drop flag 0, watchdog count 0, wdt_err 0; grants 0.
REQ-025 During reset stall SHALL be 000000 and flush 0, if_discard 0, regardless of inputs.
REQ-026 Reset mid-access SHALL abandon the access; a later stray mem_done SHALL be ignored.

Configuration
REQ-027 Macro PIPE_CTRL_WDT_EN SHALL compile in an 8-bit counter counting cycles in IF_ACC/MEM_ACC, cleared in IDLE; reaching WDT_LIMIT SHALL set wdt_err until reset.
REQ-028 Without PIPE_CTRL_WDT_EN, no counter SHALL exist and wdt_err SHALL be tied 0; all other behaviour identical.

Structure
REQ-029 Stop/NoStop, the five stall encodings and the FSM state encodings SHALL live in defines.v.
REQ-030 The watchdog SHALL be sub-module pipe_ctrl_wdt, instantiated only under PIPE_CTRL_WDT_EN.

Verification
REQ-031 if_req=1, mem_req=1 together in IDLE -> grant_mem=1 next cycle, stall=011111 until mem_done, then IDLE, then grant_if.
REQ-032 if_req=1, mem_done 3 cycles after grant -> stall=000011 each waiting cycle, 000000 in the mem_done cycle.
REQ-033 ex_stallreq=1 with branch_flag=1 -> stall=001111, flush=0; drop ex_stallreq -> flush=1 that cycle.
REQ-034 branch_flag with stall=000000 in IF_ACC, mem_done two cycles later -> flush=1 once, if_discard=1 exactly on the mem_done cycle.
REQ-035 rst low for one edge during MEM_ACC, then mem_done -> state IDLE, grant_mem=0, stall=000000, mem_done ignored.
REQ-036 PIPE_CTRL_WDT_EN with WDT_LIMIT=4, no mem_done -> wdt_err=1 after the 4th access cycle, stays 1 after mem_done; without macro stays 0.
